// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_pkg;

    localparam int unsigned DEFAULT_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DRAIN
    } ccff_state_e;

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-word readback collector: packs captured tail bits MSB-first and
// left-aligns a final short word on flush.
module ccff_rb_packer
    import ccff_pkg::*;
#(
    parameter int unsigned WORD_W = DEFAULT_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              cap_i,
    input  logic              bit_i,
    input  logic              flush_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    output logic              partial_o
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sr_q, sr_d, sr_cap_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_cap_c;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              partial_q, partial_d;

    // A capture and a flush may land on the same edge; the captured bit is
    // folded in before deciding whether the word is full or short.
    always_comb begin
        sr_cap_c  = cap_i ? {sr_q[WORD_W-2:0], bit_i} : sr_q;
        cnt_cap_c = cap_i ? cnt_q + CNT_W'(1) : cnt_q;
        sr_d      = sr_cap_c;
        cnt_d     = cnt_cap_c;
        data_d    = data_q;
        valid_d   = 1'b0;
        partial_d = partial_q;
        if (clr_i) begin
            sr_d      = '0;
            cnt_d     = '0;
            partial_d = 1'b0;
        end else if (cnt_cap_c == CNT_W'(WORD_W)) begin
            data_d  = sr_cap_c;
            valid_d = 1'b1;
            sr_d    = '0;
            cnt_d   = '0;
        end else if (flush_i && (cnt_cap_c != '0)) begin
            data_d    = sr_cap_c << (CNT_W'(WORD_W) - cnt_cap_c);
            valid_d   = 1'b1;
            partial_d = 1'b1;
            sr_d      = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign partial_o = partial_q;

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: serialises host words onto ccff_head with a
// gated shift enable and returns the displaced chain contents as readback.
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 42,
    parameter int unsigned WORD_W    = DEFAULT_WORD_W,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done,
    output logic              rb_partial
);

    localparam int unsigned TXL_W = $clog2(WORD_W + 1);

    ccff_state_e       state_q, state_d;
    logic [CNT_W-1:0]  bits_q, bits_d, remain_c;
    logic [TXL_W-1:0]  tx_left_q, tx_left_d;
    logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
    logic              head_q, head_d;
    logic              sen_q, sen_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rb_clr_c, rb_flush_c;

    assign remain_c = CNT_W'(CHAIN_LEN) - bits_q;

    // Next-state and registered-output decode; the enable is registered so the
    // chain shifts on the edge ending the cycle after a bit is taken from tx_sr.
    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        tx_left_d  = tx_left_q;
        tx_sr_d    = tx_sr_q;
        head_d     = head_q;
        sen_d      = 1'b0;
        done_d     = 1'b0;
        rb_clr_c   = 1'b0;
        rb_flush_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bits_d   = '0;
                    rb_clr_c = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                if (wr_valid && ready_q) begin
                    tx_sr_d   = wr_data;
                    tx_left_d = (32'(remain_c) > WORD_W) ? TXL_W'(WORD_W) : TXL_W'(remain_c);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                head_d    = tx_sr_q[WORD_W-1];
                sen_d     = 1'b1;
                tx_sr_d   = tx_sr_q << 1;
                bits_d    = bits_q + CNT_W'(1);
                tx_left_d = tx_left_q - TXL_W'(1);
                if ((bits_q + CNT_W'(1)) == CNT_W'(CHAIN_LEN)) begin
                    state_d = DRAIN;
                end else if (tx_left_q == TXL_W'(1)) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                rb_flush_c = 1'b1;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q   <= IDLE;
            bits_q    <= '0;
            tx_left_q <= '0;
            tx_sr_q   <= '0;
            head_q    <= 1'b0;
            sen_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bits_q    <= bits_d;
            tx_left_q <= tx_left_d;
            tx_sr_q   <= tx_sr_d;
            head_q    <= head_d;
            sen_q     <= sen_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    ccff_rb_packer #(
        .WORD_W(WORD_W)
    ) u_rb_packer (
        .clk      (prog_clk),
        .rst_n    (pReset),
        .clr_i    (rb_clr_c),
        .cap_i    (sen_q),
        .bit_i    (ccff_tail),
        .flush_i  (rb_flush_c),
        .data_o   (rb_data),
        .valid_o  (rb_valid),
        .partial_o(rb_partial)
    );

    assign wr_ready      = ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = sen_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (42-bit and 64-bit chains) driven in
// lockstep against behavioural chain models and a readback scoreboard.
module tb_ccff_loader;
    import ccff_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned LEN0 = 42;
    localparam int unsigned LEN1 = 64;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          stall;
        bit          mid_start;
        bit          part0;
        bit          part1;
    } vec_t;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic        start;
    logic [W-1:0] wr_data [2];
    logic        wr_valid [2];
    logic        wr_ready [2];
    logic        head [2];
    logic        sen [2];
    logic        tail [2];
    logic [W-1:0] rbd [2];
    logic        rbv [2];
    logic        busy [2];
    logic        done [2];
    logic        rbp [2];
    logic [63:0] chain [2];
    logic        chain_clr;

    int total = 0;
    int bad   = 0;

    logic [31:0] rbq0 [$];
    logic [31:0] rbq1 [$];
    logic [31:0] hw [2][2];
    int          host_idx [2];
    int          stall_left [2];
    bit          ready_prev [2];
    bit          prev_sen [2];
    bit          exp_part [2];
    int          shifts [2];
    int          dones [2];
    logic [63:0] exp_chain [2];

    always #5 prog_clk = ~prog_clk;

    ccff_loader #(.CHAIN_LEN(LEN0), .WORD_W(W)) dut0 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .wr_data(wr_data[0]), .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]),
        .ccff_head(head[0]), .ccff_shift_en(sen[0]), .ccff_tail(tail[0]),
        .rb_data(rbd[0]), .rb_valid(rbv[0]), .busy(busy[0]), .done(done[0]),
        .rb_partial(rbp[0])
    );

    ccff_loader #(.CHAIN_LEN(LEN1), .WORD_W(W)) dut1 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .wr_data(wr_data[1]), .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]),
        .ccff_head(head[1]), .ccff_shift_en(sen[1]), .ccff_tail(tail[1]),
        .rb_data(rbd[1]), .rb_valid(rbv[1]), .busy(busy[1]), .done(done[1]),
        .rb_partial(rbp[1])
    );

    function automatic int unsigned clen(input int i);
        return (i == 0) ? LEN0 : LEN1;
    endfunction

    function automatic logic [63:0] lmask(input int i);
        return (i == 0) ? ((64'd1 << LEN0) - 64'd1) : {64{1'b1}};
    endfunction

    // Chain model: bit 0 sits next to ccff_head, bit len-1 drives ccff_tail.
    assign tail[0] = chain[0][LEN0-1];
    assign tail[1] = chain[1][LEN1-1];

    always @(posedge prog_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (chain_clr) chain[i] <= '0;
            else if (sen[i]) chain[i] <= ((chain[i] << 1) | 64'(head[i])) & lmask(i);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int i);
        return 64'({wr_ready[i], head[i], sen[i], rbv[i], busy[i], done[i], rbp[i], rbd[i]});
    endfunction

    task automatic sample();
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            if (sen[i]) shifts[i]++;
            if (rbv[i]) begin
                if ((i == 0 && rbq0.size() == 0) || (i == 1 && rbq1.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL rb_extra dut%0d: got %h want none", i, rbd[i]);
                end else begin
                    if (i == 0) e = rbq0.pop_front();
                    else        e = rbq1.pop_front();
                    check($sformatf("rb_word dut%0d", i), 64'(rbd[i]), 64'(e));
                end
            end
            if (done[i]) begin
                dones[i]++;
                check($sformatf("done_gap dut%0d", i), 64'({prev_sen[i], sen[i]}), 64'(2'b10));
                check($sformatf("shift_total dut%0d", i), 64'(shifts[i]), 64'(clen(i)));
                check($sformatf("rb_partial dut%0d", i), 64'(rbp[i]), 64'(exp_part[i]));
                check($sformatf("rb_left dut%0d", i),
                      64'((i == 0) ? rbq0.size() : rbq1.size()), 64'(0));
            end
            prev_sen[i] = sen[i];
        end
    endtask

    // Host model: offers words in order, optionally stalling before word 1.
    task automatic host();
        for (int i = 0; i < 2; i++) begin
            if (wr_valid[i] && ready_prev[i]) host_idx[i]++;
            wr_valid[i] = 1'b0;
            if (host_idx[i] < 2) begin
                if (host_idx[i] == 1 && stall_left[i] > 0) begin
                    if (wr_ready[i]) begin
                        if (ready_prev[i]) check($sformatf("stall_quiet dut%0d", i), 64'(sen[i]), 64'(0));
                        stall_left[i]--;
                    end
                end else begin
                    wr_valid[i] = 1'b1;
                    wr_data[i]  = hw[i][host_idx[i]];
                end
            end
            ready_prev[i] = wr_ready[i];
        end
    endtask

    task automatic cycle();
        @(negedge prog_clk);
        sample();
        host();
    endtask

    task automatic begin_load(input logic [31:0] w0, input logic [31:0] w1, input int stall,
                              input bit p0, input bit p1);
        logic [63:0] x;
        for (int i = 0; i < 2; i++) begin
            hw[i][0]      = w0;
            hw[i][1]      = w1;
            host_idx[i]   = 0;
            stall_left[i] = stall;
            shifts[i]     = 0;
            exp_chain[i]  = {w0, w1} >> (64 - clen(i));
            x = chain[i] << (64 - clen(i));
            if (i == 0) begin
                rbq0.push_back(x[63:32]);
                rbq0.push_back(x[31:0]);
            end else begin
                rbq1.push_back(x[63:32]);
                rbq1.push_back(x[31:0]);
            end
        end
        exp_part[0] = p0;
        exp_part[1] = p1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("start_ready dut%0d", i), 64'({wr_ready[i], busy[i]}), 64'(2'b11));
        end
    endtask

    task automatic run_load(input vec_t v);
        int base0, base1, n;
        base0 = dones[0];
        base1 = dones[1];
        begin_load(v.w0, v.w1, v.stall, v.part0, v.part1);
        n = 0;
        while (!(dones[0] > base0 && dones[1] > base1) && n < 400) begin
            cycle();
            start = v.mid_start && (shifts[0] == 5);
            n++;
        end
        start = 1'b0;
        check("load_finished", 64'(n < 400), 64'(1));
        repeat (3) cycle();
        check("done_once dut0", 64'(dones[0] - base0), 64'(1));
        check("done_once dut1", 64'(dones[1] - base1), 64'(1));
        for (int i = 0; i < 2; i++) begin
            check($sformatf("chain dut%0d", i), chain[i], exp_chain[i]);
            check($sformatf("idle dut%0d", i), 64'({busy[i], wr_ready[i], sen[i]}), 64'(0));
        end
    endtask

    vec_t vecs [6];

    initial begin
        vec_t        v;
        logic [63:0] old [2];
        logic [31:0] wa;
        int          n, base0, base1;

        vecs[0] = '{w0: 32'hA5A5_A5A5, w1: 32'hC000_0000, stall: 0,  mid_start: 0, part0: 1, part1: 0};
        vecs[1] = '{w0: 32'h3C96_F00D, w1: 32'h8E1D_2B47, stall: 0,  mid_start: 0, part0: 1, part1: 0};
        vecs[2] = '{w0: 32'hC369_0FF2, w1: 32'h71E2_D4B8, stall: 0,  mid_start: 0, part0: 1, part1: 0};
        vecs[3] = '{w0: 32'hC369_0FF2, w1: 32'h71E2_D4B8, stall: 20, mid_start: 0, part0: 1, part1: 0};
        vecs[4] = '{w0: 32'hDEAD_BEEF, w1: 32'h0BAD_F00D, stall: 5,  mid_start: 1, part0: 1, part1: 0};
        vecs[5] = '{w0: 32'h1234_5678, w1: 32'h9ABC_DEF0, stall: 0,  mid_start: 0, part0: 1, part1: 0};

        pReset    = 1'b0;
        start     = 1'b0;
        chain_clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_data[i]    = '0;
            wr_valid[i]   = 1'b0;
            host_idx[i]   = 2;
            stall_left[i] = 0;
            ready_prev[i] = 1'b0;
            prev_sen[i]   = 1'b0;
            exp_part[i]   = 1'b0;
            shifts[i]     = 0;
            dones[i]      = 0;
        end
        repeat (3) cycle();
        for (int i = 0; i < 2; i++) check($sformatf("reset_outs dut%0d", i), outs(i), 64'(0));
        chain_clr = 1'b0;
        pReset    = 1'b1;
        cycle();

        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            run_load(v);
        end

        // Abort: reset lands right after the 17th shift edge of a fresh load.
        base0 = dones[0];
        base1 = dones[1];
        wa    = 32'hF0F0_1234;
        for (int i = 0; i < 2; i++) old[i] = chain[i];
        begin_load(wa, 32'h5555_AAAA, 0, 1'b0, 1'b0);
        n = 0;
        while (shifts[0] < 17 && n < 200) begin
            cycle();
            n++;
        end
        check("abort_reached", 64'(shifts[0]), 64'(17));
        @(posedge prog_clk);
        #1;
        pReset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("abort_outs dut%0d", i), outs(i), 64'(0));
        rbq0.delete();
        rbq1.delete();
        for (int i = 0; i < 2; i++) host_idx[i] = 2;
        repeat (3) cycle();
        check("abort_no_done dut0", 64'(dones[0] - base0), 64'(0));
        check("abort_no_done dut1", 64'(dones[1] - base1), 64'(0));
        for (int i = 0; i < 2; i++) begin
            check($sformatf("abort_chain dut%0d", i), chain[i],
                  ((old[i] << 17) | 64'(wa >> 15)) & lmask(i));
        end
        pReset = 1'b1;
        cycle();

        v = vecs[5];
        run_load(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
